pattern_count_engine: RTL and testbench
=======================================

Name: pattern_count_engine

Overview:
- Hardware accelerator for the bit-pattern search program. It scans NBYTES bytes of data memory for a PAT_W-bit pattern and produces three counts:
  - pattern hits confined within a byte;
  - number of bytes holding at least one hit;
  - hits in the continuous bitstream, including byte-crossing hits.
- The three counts are written back to data memory, then Ack is raised.
- Sits beside the core on the single data-memory port; the core hands the port over while Busy is high.

Parameters:
PAT_W, 5, pattern width in bits; legal 2..8
NBYTES, 32, bytes scanned from address 0; legal 1..(2**ADDR_W - PAT_ADDR_OFS)
ADDR_W, 8, data-memory address width
PAT_ADDR, 32, address of the pattern byte; pattern occupies bits [7:8-PAT_W]
RES_ADDR, 33, result base: RES_ADDR=within-byte, +1=bytes-with-hit, +2=bitstream

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  one-cycle pulse; begin a run
MemAddr  out  ADDR_W  data-memory address (read and write)
MemRdData  in  8  combinational read data for MemAddr, same cycle
MemWrEn  out  1  write strobe; write MemWrData to MemAddr at rising edge
MemWrData  out  8  write data
Busy  out  1  high from the first cycle after Start is accepted until Ack rises
Ack  out  1  level; high after results are written, held until next accepted Start

Behaviour:
- Reset (async): state IDLE; MemAddr=0, MemWrEn=0, MemWrData=0, Busy=0, Ack=0; all counters 0, tail register 0.
- FSM: IDLE -> LDPAT -> SCAN -> WR0 -> WR1 -> WR2 -> DONE.
- IDLE/DONE + Start=1: accept the run.
  - Clear counters and tail; drop Ack; go to LDPAT.
- Start in any other state: ignored.
- LDPAT (1 cycle): MemAddr=PAT_ADDR; latch pat=MemRdData[7:8-PAT_W]; go to SCAN with index i=0.
- SCAN (NBYTES cycles, one byte per cycle): MemAddr=i; b=MemRdData.
  - Within-byte hits, h = count of k in 0..8-PAT_W with b[k+PAT_W-1:k]==pat.
    - ctb += h.
    - cto += (h!=0).
  - Bitstream, byte 0 is first and each byte is MSB-first:
    - For i=0: cts += h.
    - For i>=1: window w={tail,b}, width PAT_W-1+8; cts += count of k in 0..7 with w[k+PAT_W-1:k]==pat.
  - Then tail <= b[PAT_W-2:0].
  - After i=NBYTES-1, go to WR0.
- Counters are 16 bits internally.
- WR0/WR1/WR2: MemWrEn=1; MemAddr=RES_ADDR, +1, +2; data = ctb, cto, cts respectively. Each value saturates to 8'hFF if >255.
- DONE: MemWrEn=0; Ack=1, Busy=0; hold until an accepted Start or Reset.
- Latency: Start sampled at edge 0 -> Ack high after edge NBYTES+5 (37 cycles at defaults).
- Busy high from edge 1 through edge NBYTES+4.
- MemWrEn is high only in WR0..WR2; no memory write in any other state.
- Pattern at PAT_ADDR inside the scan range (PAT_ADDR<NBYTES): that byte is scanned as ordinary data.
- Reset mid-run: immediate abort. No further writes; Ack=0; results already written stay in memory. The next Start runs cleanly.
- Start in the same cycle as Reset: Reset wins; stay in IDLE.
- Totals: ctb max NBYTES*(9-PAT_W); cts max 8*NBYTES-PAT_W+1.

Test Plan:
- Memory 0..31=8'h00, pattern byte 8'h00, defaults -> Core[33]=128, Core[34]=32, Core[35]=252; Ack 37 cycles after Start; Busy deasserts as Ack rises.
- Memory 0..31=8'h55, pattern 5'b10101 (byte 8'hA8) -> Core[33]=64, Core[34]=32, Core[35]=126.
- All bytes 8'h00 except byte 5=8'hFF, pattern 5'b11111 -> 4, 1, 4.
- Byte-crossing only: byte 3=8'h07, byte 4=8'hC0, rest 0, pattern 5'b11111 -> 0, 0, 1.
- Saturation: NBYTES=64, PAT_ADDR=64, RES_ADDR=65, all zero, pattern 0 -> ctb raw 256 written 255, cto 64, cts raw 508 written 255.
- Robustness:
  - Reset pulse mid-SCAN -> MemWrEn never asserts and Ack stays 0.
  - Extra Start pulses during SCAN -> ignored.
  - A fresh Start then yields the same results as an uninterrupted run; a second run after Ack lowers Ack on Start and reproduces the results.

Source files
------------

// File: rtl/pattern_count_engine_if.sv
// rtl/pattern_count_engine_if.sv - start/ack handshake and data-memory port of the pattern count engine
interface pattern_count_engine_if #(
    parameter int ADDR_W = 8
);
    logic              Start;
    logic [ADDR_W-1:0] MemAddr;
    logic [7:0]        MemRdData;
    logic              MemWrEn;
    logic [7:0]        MemWrData;
    logic              Busy;
    logic              Ack;

    modport master (
        input  Start, MemRdData,
        output MemAddr, MemWrEn, MemWrData, Busy, Ack
    );

    modport slave (
        output Start, MemRdData,
        input  MemAddr, MemWrEn, MemWrData, Busy, Ack
    );
endinterface

// File: rtl/pattern_count_engine.sv
// rtl/pattern_count_engine.sv - scans data memory for a bit pattern and writes back three hit counts
module pattern_count_engine #(
    parameter int PAT_W    = 5,
    parameter int NBYTES   = 32,
    parameter int ADDR_W   = 8,
    parameter int PAT_ADDR = 32,
    parameter int RES_ADDR = 33
) (
    input  logic Clk,
    input  logic Reset,
    pattern_count_engine_if.master bus
);
    typedef enum logic [2:0] {IDLE, LDPAT, SCAN, WR0, WR1, WR2, DONE} state_t;

    state_t            state, state_nx;
    logic              start_q;
    logic              accept;
    logic              last_byte;
    logic [ADDR_W-1:0] idx;
    logic [PAT_W-1:0]  pat;
    logic [PAT_W-2:0]  tail;
    logic [15:0]       ctb, cto, cts;
    logic [3:0]        hit_in, hit_x;
    logic [PAT_W+6:0]  win;

    function automatic logic [7:0] sat(input logic [15:0] v);
        return (v > 16'd255) ? 8'hFF : v[7:0];
    endfunction

    // Start is registered only while idle, so pulses during a run never queue up.
    assign accept    = start_q && (state == IDLE || state == DONE);
    assign last_byte = (idx == ADDR_W'(NBYTES - 1));
    assign bus.Busy  = !(state == IDLE || state == DONE);
    assign bus.Ack   = (state == DONE);

    always_comb begin
        hit_in = 4'd0;
        for (int k = 0; k <= 8 - PAT_W; k++) begin
            if (bus.MemRdData[k +: PAT_W] == pat) hit_in = hit_in + 4'd1;
        end
        // Tail bits of the previous byte sit above the current byte: MSB-first stream order.
        win   = {tail, bus.MemRdData};
        hit_x = 4'd0;
        for (int k = 0; k < 8; k++) begin
            if (win[k +: PAT_W] == pat) hit_x = hit_x + 4'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.MemAddr   = '0;
        bus.MemWrEn   = 1'b0;
        bus.MemWrData = 8'h00;
        case (state)
            IDLE, DONE: if (accept) state_nx = LDPAT;
            LDPAT: begin
                bus.MemAddr = ADDR_W'(PAT_ADDR);
                state_nx    = SCAN;
            end
            SCAN: begin
                bus.MemAddr = idx;
                if (last_byte) state_nx = WR0;
            end
            WR0: begin
                bus.MemWrEn   = 1'b1;
                bus.MemAddr   = ADDR_W'(RES_ADDR);
                bus.MemWrData = sat(ctb);
                state_nx      = WR1;
            end
            WR1: begin
                bus.MemWrEn   = 1'b1;
                bus.MemAddr   = ADDR_W'(RES_ADDR + 1);
                bus.MemWrData = sat(cto);
                state_nx      = WR2;
            end
            WR2: begin
                bus.MemWrEn   = 1'b1;
                bus.MemAddr   = ADDR_W'(RES_ADDR + 2);
                bus.MemWrData = sat(cts);
                state_nx      = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            start_q <= 1'b0;
            idx     <= '0;
            pat     <= '0;
            tail    <= '0;
            ctb     <= 16'd0;
            cto     <= 16'd0;
            cts     <= 16'd0;
        end else begin
            start_q <= bus.Start && !bus.Busy;
            if (accept) begin
                ctb  <= 16'd0;
                cto  <= 16'd0;
                cts  <= 16'd0;
                tail <= '0;
                idx  <= '0;
            end
            if (state == LDPAT) begin
                pat <= bus.MemRdData[7 -: PAT_W];
                idx <= '0;
            end
            if (state == SCAN) begin
                ctb  <= ctb + {12'd0, hit_in};
                cto  <= cto + {15'd0, hit_in != 4'd0};
                cts  <= cts + ((idx == '0) ? {12'd0, hit_in} : {12'd0, hit_x});
                tail <= bus.MemRdData[PAT_W-2:0];
                idx  <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pattern_count_engine.sv
// tb/tb_pattern_count_engine.sv - randomized and directed bench for pattern_count_engine
module tb_pattern_count_engine;
    localparam int PW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pattern_count_engine_if #(.ADDR_W(8)) ifa ();
    pattern_count_engine_if #(.ADDR_W(8)) ifb ();

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] wr_a  [256];
    logic [7:0] wr_b  [256];
    int wr_cnt_a = 0, wr_cnt_b = 0, bad_a = 0, bad_b = 0;
    int checks = 0, failures = 0;

    assign ifa.MemRdData = mem_a[ifa.MemAddr];
    assign ifb.MemRdData = mem_b[ifb.MemAddr];

    pattern_count_engine #(.PAT_W(PW), .NBYTES(32), .ADDR_W(8), .PAT_ADDR(32), .RES_ADDR(33)) dut_a (
        .Clk(clk), .Reset(rst), .bus(ifa.master)
    );
    pattern_count_engine #(.PAT_W(PW), .NBYTES(64), .ADDR_W(8), .PAT_ADDR(64), .RES_ADDR(65)) dut_b (
        .Clk(clk), .Reset(rst), .bus(ifb.master)
    );

    always @(posedge clk) begin
        if (ifa.MemWrEn) begin
            wr_a[ifa.MemAddr] <= ifa.MemWrData;
            wr_cnt_a <= wr_cnt_a + 1;
            if (ifa.MemAddr < 8'd33 || ifa.MemAddr > 8'd35) bad_a <= bad_a + 1;
        end
        if (ifb.MemWrEn) begin
            wr_b[ifb.MemAddr] <= ifb.MemWrData;
            wr_cnt_b <= wr_cnt_b + 1;
            if (ifb.MemAddr < 8'd65 || ifb.MemAddr > 8'd67) bad_b <= bad_b + 1;
        end
    end

    function automatic logic get_ack(input bit sel);
        return sel ? ifb.Ack : ifa.Ack;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? ifb.Busy : ifa.Busy;
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) ifb.Start = v;
        else     ifa.Start = v;
    endtask

    // Reference: within-byte windows per byte, and a flat MSB-first bit list for the stream count.
    function automatic void model(input bit sel, output int e0, output int e1, output int e2);
        int n, pa, pat, h, v;
        logic [7:0] b;
        bit stream[$];
        n  = sel ? 64 : 32;
        pa = sel ? 64 : 32;
        b  = sel ? mem_b[pa] : mem_a[pa];
        pat = int'(b) >> (8 - PW);
        e0 = 0; e1 = 0; e2 = 0;
        for (int i = 0; i < n; i++) begin
            b = sel ? mem_b[i] : mem_a[i];
            h = 0;
            for (int s = 0; s <= 8 - PW; s++)
                if (((int'(b) >> s) & ((1 << PW) - 1)) == pat) h++;
            e0 += h;
            if (h > 0) e1++;
            for (int j = 7; j >= 0; j--) stream.push_back(b[j]);
        end
        for (int p = 0; p + PW <= stream.size(); p++) begin
            v = 0;
            for (int j = 0; j < PW; j++) v = (v << 1) | int'(stream[p + j]);
            if (v == pat) e2++;
        end
        if (e0 > 255) e0 = 255;
        if (e1 > 255) e1 = 255;
        if (e2 > 255) e2 = 255;
    endfunction

    task automatic fill_random(input bit sel);
        int n;
        logic [7:0] v;
        n = sel ? 64 : 32;
        for (int i = 0; i <= n; i++) begin
            v = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            if (sel) mem_b[i] = v;
            else     mem_a[i] = v;
        end
    endtask

    task automatic run(input bit sel, input bit extra, input int e0, input int e1, input int e2,
                       input string name);
        int n, res, cyc, wc0, bad0;
        logic busy1, ack1, busy_prev;
        n    = sel ? 64 : 32;
        res  = sel ? 65 : 33;
        wc0  = sel ? wr_cnt_b : wr_cnt_a;
        bad0 = sel ? bad_b : bad_a;
        busy1 = 1'b0; ack1 = 1'b1; busy_prev = 1'b0;
        @(negedge clk); set_start(sel, 1'b1);
        @(negedge clk); set_start(sel, 1'b0);
        cyc = 0;
        while (cyc < n + 40) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (extra && cyc == 8) set_start(sel, 1'b1);
            if (extra && cyc == 9) set_start(sel, 1'b0);
            if (cyc == 1) begin busy1 = get_busy(sel); ack1 = get_ack(sel); end
            if (get_ack(sel)) break;
            busy_prev = get_busy(sel);
        end
        checks++; if (ack1 !== 1'b0) begin failures++; $display("FAIL %s ack_drop got=%b want=0", name, ack1); end
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL %s busy_rise got=%b want=1", name, busy1); end
        checks++; if (cyc !== n + 5) begin failures++; $display("FAIL %s latency got=%0d want=%0d", name, cyc, n + 5); end
        checks++; if (get_busy(sel) !== 1'b0 || busy_prev !== 1'b1) begin
            failures++; $display("FAIL %s busy_fall got=%b/%b want=1/0", name, busy_prev, get_busy(sel));
        end
        checks++; if ((sel ? wr_cnt_b : wr_cnt_a) - wc0 !== 3) begin
            failures++; $display("FAIL %s write_count got=%0d want=3", name, (sel ? wr_cnt_b : wr_cnt_a) - wc0);
        end
        checks++; if ((sel ? bad_b : bad_a) !== bad0) begin
            failures++; $display("FAIL %s stray_write got=%0d want=%0d", name, sel ? bad_b : bad_a, bad0);
        end
        checks++; if (int'(sel ? wr_b[res] : wr_a[res]) !== e0) begin
            failures++; $display("FAIL %s ctb got=%0d want=%0d", name, sel ? wr_b[res] : wr_a[res], e0);
        end
        checks++; if (int'(sel ? wr_b[res+1] : wr_a[res+1]) !== e1) begin
            failures++; $display("FAIL %s cto got=%0d want=%0d", name, sel ? wr_b[res+1] : wr_a[res+1], e1);
        end
        checks++; if (int'(sel ? wr_b[res+2] : wr_a[res+2]) !== e2) begin
            failures++; $display("FAIL %s cts got=%0d want=%0d", name, sel ? wr_b[res+2] : wr_a[res+2], e2);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (ifa.MemAddr !== 8'd0) begin failures++; $display("FAIL reset_addr got=%0d want=0", ifa.MemAddr); end
        checks++; if (ifa.MemWrEn !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b want=0", ifa.MemWrEn); end
        checks++; if (ifa.MemWrData !== 8'd0) begin failures++; $display("FAIL reset_wdata got=%0d want=0", ifa.MemWrData); end
        checks++; if (ifa.Busy !== 1'b0 || ifb.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b%b want=00", ifa.Busy, ifb.Busy); end
        checks++; if (ifa.Ack !== 1'b0 || ifb.Ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b%b want=00", ifa.Ack, ifb.Ack); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        for (int i = 0; i < 32; i++) mem_a[i] = 8'h00;
        mem_a[32] = 8'h00;
        run(0, 0, 128, 32, 252, "zeros");
        for (int i = 0; i < 32; i++) mem_a[i] = 8'h55;
        mem_a[32] = 8'hA8;
        run(0, 0, 64, 32, 126, "alt55");
        for (int i = 0; i < 32; i++) mem_a[i] = 8'h00;
        mem_a[5] = 8'hFF; mem_a[32] = 8'hF8;
        run(0, 0, 4, 1, 4, "single_ff");
        mem_a[5] = 8'h00; mem_a[3] = 8'h07; mem_a[4] = 8'hC0;
        run(0, 0, 0, 0, 1, "crossing");
    endtask

    task automatic test_saturation();
        for (int i = 0; i <= 64; i++) mem_b[i] = 8'h00;
        run(1, 0, 255, 64, 255, "saturate");
    endtask

    task automatic test_random();
        int e0, e1, e2;
        for (int r = 0; r < 5; r++) begin
            fill_random(0);
            model(0, e0, e1, e2);
            run(0, 0, e0, e1, e2, "random_a");
        end
        fill_random(1);
        model(1, e0, e1, e2);
        run(1, 0, e0, e1, e2, "random_b");
    endtask

    task automatic test_extra_start();
        int e0, e1, e2;
        fill_random(0);
        model(0, e0, e1, e2);
        run(0, 1, e0, e1, e2, "extra_start");
    endtask

    task automatic test_reset_mid_scan();
        int e0, e1, e2, wc0;
        logic ack_seen;
        fill_random(0);
        model(0, e0, e1, e2);
        wc0 = wr_cnt_a;
        ack_seen = 1'b0;
        @(negedge clk); ifa.Start = 1'b1;
        @(negedge clk); ifa.Start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (ifa.Ack) ack_seen = 1'b1;
        end
        checks++; if (wr_cnt_a !== wc0) begin failures++; $display("FAIL abort_writes got=%0d want=%0d", wr_cnt_a, wc0); end
        checks++; if (ack_seen !== 1'b0) begin failures++; $display("FAIL abort_ack got=%b want=0", ack_seen); end
        checks++; if (ifa.Busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", ifa.Busy); end
        run(0, 0, e0, e1, e2, "after_abort");
    endtask

    task automatic test_back_to_back();
        int e0, e1, e2;
        fill_random(0);
        model(0, e0, e1, e2);
        run(0, 0, e0, e1, e2, "b2b_first");
        run(0, 0, e0, e1, e2, "b2b_second");
    endtask

    task automatic test_start_with_reset();
        @(negedge clk); rst = 1'b1; ifa.Start = 1'b1;
        @(negedge clk); rst = 1'b0; ifa.Start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ifa.Busy !== 1'b0) begin failures++; $display("FAIL start_reset_busy got=%b want=0", ifa.Busy); end
        checks++; if (ifa.Ack !== 1'b0) begin failures++; $display("FAIL start_reset_ack got=%b want=0", ifa.Ack); end
    endtask

    initial begin
        ifa.Start = 1'b0;
        ifb.Start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_directed();
        test_saturation();
        test_random();
        test_extra_start();
        test_reset_mid_scan();
        test_back_to_back();
        test_start_with_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end
endmodule
